inj_scan_ctrl: RTL

- CLK40-domain sequencer that runs a burst of injection pulses, each bracketed by a TDC gate window, and counts monitor responses inside each window.
- It owns the injection and gate resources during a scan: drives INJECTION and GATE_TDC, and reports progress and hit statistics.
- Configuration arrives on parallel ports from the surrounding core (GPIO/register block) and is latched at START.

---
 rtl/inj_scan_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/inj_scan_ctrl.sv
// Injection burst sequencer: gated pulse windows on CLK40
// with per-window hit counting on the synchronised monitor.
module inj_scan_ctrl #(
  parameter int CNT_WIDTH = 16,
  parameter int TW        = 8
) (
  input  logic                 CLK40,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [CNT_WIDTH-1:0] INJ_COUNT,
  input  logic [CNT_WIDTH-1:0] INJ_PERIOD,
  input  logic [TW-1:0]        GATE_PRE,
  input  logic [TW-1:0]        INJ_WIDTH,
  input  logic [TW-1:0]        GATE_POST,
  input  logic                 MONITOR_SYNC,
  output logic                 INJECTION,
  output logic                 GATE_TDC,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CNT_WIDTH-1:0] INJ_DONE_CNT,
  output logic [CNT_WIDTH-1:0] HIT_CNT
);

  localparam int PW =
    ((CNT_WIDTH > TW + 2) ? CNT_WIDTH : TW + 2) + 1;

  typedef enum logic [2:0] {
    IDLE, PRE, PULSE, POST, WAIT, FINISH
  } state_t;

  state_t state, state_n, first;

  logic                 arm;
  logic                 accept;
  logic                 hit;
  logic                 last;
  logic                 pulse_end;
  logic                 mon_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [PW-1:0]        per_q;
  logic [TW-1:0]        pre_q;
  logic [TW-1:0]        w_q;
  logic [TW-1:0]        post_q;
  logic [PW-1:0]        t;
  logic [PW-1:0]        t_nx;
  logic [PW-1:0]        e1;
  logic [PW-1:0]        e2;
  logic [PW-1:0]        e3;
  logic [PW-1:0]        peff;

  // arm marks the setup cycle between START and the first window
  assign accept = START && !ABORT
               && state == IDLE && !arm;

  assign e1   = PW'(pre_q);
  assign e2   = e1 + PW'(w_q);
  assign e3   = e2 + PW'(post_q);
  assign peff = (per_q > e3) ? per_q : e3 + 1'b1;
  assign t_nx = t + 1'b1;

  assign first = (pre_q != '0) ? PRE : PULSE;
  assign last  = (INJ_DONE_CNT + 1'b1) == cnt_q;

  assign pulse_end = (state == PULSE) && (t_nx == e2);

  assign hit = MONITOR_SYNC && !mon_q && GATE_TDC
            && BUSY && !ABORT;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (arm)
          state_n = (cnt_q == '0) ? FINISH : first;
      PRE:
        if (t_nx == e1) state_n = PULSE;
      PULSE:
        if (t_nx == e2) begin
          if (post_q != '0) state_n = POST;
          else state_n = last ? FINISH : WAIT;
        end
      POST:
        if (t_nx == e3)
          state_n = (INJ_DONE_CNT == cnt_q) ? FINISH : WAIT;
      WAIT:
        if (t_nx == peff) state_n = first;
      FINISH:
        state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
    if (ABORT) state_n = IDLE;
  end

  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      arm   <= 1'b0;
      t     <= '0;
    end else begin
      state <= state_n;
      arm   <= accept;
      if (state == IDLE || state == FINISH
          || (state == WAIT && t_nx == peff))
        t <= '0;
      else
        t <= t_nx;
    end
  end

  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= '0;
      per_q  <= '0;
      pre_q  <= '0;
      w_q    <= '0;
      post_q <= '0;
    end else if (accept) begin
      cnt_q  <= INJ_COUNT;
      per_q  <= PW'(INJ_PERIOD);
      pre_q  <= GATE_PRE;
      w_q    <= (INJ_WIDTH == '0) ? TW'(1) : INJ_WIDTH;
      post_q <= GATE_POST;
    end
  end

  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      INJ_DONE_CNT <= '0;
      HIT_CNT      <= '0;
      mon_q        <= 1'b0;
    end else begin
      mon_q <= MONITOR_SYNC;
      if (accept) begin
        INJ_DONE_CNT <= '0;
        HIT_CNT      <= '0;
      end else begin
        if (pulse_end && !ABORT)
          INJ_DONE_CNT <= INJ_DONE_CNT + 1'b1;
        if (hit && HIT_CNT != '1)
          HIT_CNT <= HIT_CNT + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      INJECTION <= 1'b0;
      GATE_TDC  <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      INJECTION <= state_n == PULSE;
      GATE_TDC  <= state_n inside {PRE, PULSE, POST};
      BUSY      <= state_n inside {PRE, PULSE, POST, WAIT};
      DONE      <= state_n == FINISH;
    end
  end

endmodule
